// File: rtl/gpio_uart_pkg.sv
// Shared types for the GPIO-to-UART bridge.
// GPIO_UART_PARITY_EN selects 8E1 framing (PARITY state present) instead of 8N1.
package gpio_uart_pkg;

  typedef logic [7:0] byte_t;

`ifdef GPIO_UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
  localparam int unsigned FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
  localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/gpio_uart_tx_fifo.sv
// Byte FIFO between the GPIO strobe and the serialiser; head is readable
// combinationally so the FSM can load it on the pop edge.
module gpio_fifo
  import gpio_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  byte_t                    wr_data,
  output byte_t                    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// Captures GPIO byte strobes into a FIFO and sends them as UART frames.
// Define GPIO_UART_PARITY_EN for 8E1 framing; default is 8N1.
module gpio_uart_tx
  import gpio_uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               gpio_data,
  input  logic                     gpio_en,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  state_t         state, state_nxt;
  byte_t          shift_q, shift_nxt;
  logic [CW-1:0]  cyc_q, cyc_nxt;
  logic [2:0]     bit_q, bit_nxt;
  logic           tx_nxt;
  logic           cyc_last;
  logic           pop;
  logic           full;
  logic           empty;
  byte_t          head;

  gpio_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (gpio_en),
    .pop     (pop),
    .wr_data (gpio_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign pop      = (state == ST_IDLE) && !empty;
  assign cyc_last = (cyc_q == CW'(CLKS_PER_BIT - 1));

`ifdef GPIO_UART_PARITY_EN
  logic parity_q;

  // Captured at load time because the shift register is consumed during DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      parity_q <= 1'b0;
    else if (pop) parity_q <= ^head;
  end
`endif

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    cyc_nxt   = cyc_q;
    bit_nxt   = bit_q;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nxt = ST_START;
          shift_nxt = head;
          cyc_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      ST_START: begin
        cyc_nxt = cyc_q + 1'b1;
        if (cyc_last) begin
          state_nxt = ST_DATA;
          cyc_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        cyc_nxt = cyc_q + 1'b1;
        if (cyc_last) begin
          cyc_nxt   = '0;
          shift_nxt = shift_q >> 1;
          bit_nxt   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef GPIO_UART_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef GPIO_UART_PARITY_EN
      ST_PARITY: begin
        cyc_nxt = cyc_q + 1'b1;
        if (cyc_last) begin
          state_nxt = ST_STOP;
          cyc_nxt   = '0;
        end
      end
`endif
      ST_STOP: begin
        cyc_nxt = cyc_q + 1'b1;
        if (cyc_last) begin
          state_nxt = ST_IDLE;
          cyc_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line level is decided from the next state so tx leaves a flop.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
`ifdef GPIO_UART_PARITY_EN
      ST_PARITY: tx_nxt = parity_q;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift_q  <= '0;
      cyc_q    <= '0;
      bit_q    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      cyc_q   <= cyc_nxt;
      bit_q   <= bit_nxt;
      tx      <= tx_nxt;
      busy    <= (state_nxt != ST_IDLE);
      if (gpio_en && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// Build with GPIO_UART_PARITY_EN defined to also cover 8E1 framing.
module tb_gpio_uart_tx;
  import gpio_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FB    = int'(FRAME_BITS);

  logic       clk;
  logic       rst;
  logic [7:0] gpio_data;
  logic       gpio_en;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  gpio_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_data  (gpio_data),
    .gpio_en    (gpio_en),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef GPIO_UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks frame cycles first..end; cycle 0 is the edge that pops the byte.
  task automatic expect_frame(input logic [7:0] b, input int first);
    for (int i = first; i < FB*CPB; i++) begin
      tick();
      check($sformatf("frame_%02h_tx_c%0d", b, i), 32'(tx), 32'(frame_bit(b, i/CPB)));
      check($sformatf("frame_%02h_busy_c%0d", b, i), 32'(busy), 32'd1);
    end
  endtask

  task automatic expect_idle(input string tag);
    tick();
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic push(input logic [7:0] d);
    gpio_data = d;
    gpio_en   = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    gpio_en   = 1'b0;
    gpio_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    expect_idle("post_rst");

    // Single byte 0x5A
    push(8'h5A);
    tick();
    gpio_en = 1'b0;
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_tx_pre", 32'(tx), 32'd1);
    check("single_busy_pre", 32'(busy), 32'd0);
    expect_frame(8'h5A, 0);
    expect_idle("single_end");
    check("single_count_end", 32'(fifo_count), 32'd0);
    expect_idle("single_quiet");

    // Back-to-back 0x01, 0x02, 0x03
    push(8'h01);
    tick();
    check("b2b_count_k", 32'(fifo_count), 32'd1);
    push(8'h02);
    tick();
    check("b2b_count_k1", 32'(fifo_count), 32'd1);
    check("b2b_tx_c0", 32'(tx), 32'd0);
    push(8'h03);
    tick();
    gpio_en = 1'b0;
    check("b2b_count_peak", 32'(fifo_count), 32'd2);
    check("b2b_tx_c1", 32'(tx), 32'd0);
    expect_frame(8'h01, 2);
    expect_idle("b2b_gap1");
    expect_frame(8'h02, 0);
    expect_idle("b2b_gap2");
    expect_frame(8'h03, 0);
    expect_idle("b2b_end");
    check("b2b_count_end", 32'(fifo_count), 32'd0);

    // Full FIFO with a push on the pop edge
    push(8'hA0);
    tick();
    push(8'hA1);
    tick();
    push(8'hA2);
    tick();
    push(8'hA3);
    tick();
    push(8'hA4);
    tick();
    gpio_en = 1'b0;
    check("fp_count_full", 32'(fifo_count), 32'd4);
    expect_frame(8'hA0, 4);
    expect_idle("fp_gap0");
    check("fp_count_idle", 32'(fifo_count), 32'd4);
    push(8'h77);
    tick();
    gpio_en = 1'b0;
    check("fp_count_pop_edge", 32'(fifo_count), 32'd4);
    check("fp_ovf", 32'(overflow), 32'd0);
    check("fp_tx_start", 32'(tx), 32'd0);
    expect_frame(8'hA1, 1);
    expect_idle("fp_gap1");
    expect_frame(8'hA2, 0);
    expect_idle("fp_gap2");
    expect_frame(8'hA3, 0);
    expect_idle("fp_gap3");
    expect_frame(8'hA4, 0);
    expect_idle("fp_gap4");
    expect_frame(8'h77, 0);
    expect_idle("fp_end");
    check("fp_count_end", 32'(fifo_count), 32'd0);
    check("fp_ovf_end", 32'(overflow), 32'd0);

    // Overflow: 0xFF in flight, then 0x10..0x14 with only four slots
    push(8'hFF);
    tick();
    push(8'h10);
    tick();
    check("ovf_count_1", 32'(fifo_count), 32'd1);
    push(8'h11);
    tick();
    push(8'h12);
    tick();
    push(8'h13);
    tick();
    check("ovf_count_4", 32'(fifo_count), 32'd4);
    check("ovf_before", 32'(overflow), 32'd0);
    push(8'h14);
    tick();
    gpio_en = 1'b0;
    check("ovf_count_drop", 32'(fifo_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    expect_frame(8'hFF, 5);
    for (int b = 8'h10; b <= 8'h13; b++) begin
      expect_idle("ovf_gap");
      expect_frame(8'(b), 0);
    end
    for (int i = 0; i < 2*FB*CPB; i++) begin
      expect_idle("ovf_no_14");
    end
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_count_end", 32'(fifo_count), 32'd0);

`ifdef GPIO_UART_PARITY_EN
    // 0x07 has odd weight -> parity 1; 0x03 even weight -> parity 0
    push(8'h07);
    tick();
    gpio_en = 1'b0;
    for (int i = 0; i < 9*CPB; i++) tick();
    for (int i = 0; i < CPB; i++) begin
      tick();
      check("par_07_bit", 32'(tx), 32'd1);
    end
    for (int i = 0; i < CPB; i++) begin
      tick();
      check("par_07_stop", 32'(tx), 32'd1);
      check("par_07_busy", 32'(busy), 32'd1);
    end
    expect_idle("par_07_end");
    push(8'h03);
    tick();
    gpio_en = 1'b0;
    expect_frame(8'h03, 0);
    expect_idle("par_03_end");
    push(8'h03);
    tick();
    gpio_en = 1'b0;
    for (int i = 0; i < 9*CPB; i++) tick();
    tick();
    check("par_03_bit", 32'(tx), 32'd0);
    for (int i = 1; i < 2*CPB; i++) tick();
    expect_idle("par_03_end2");
`endif

    // Reset mid-frame of 0xA5 with a second byte buffered
    push(8'hA5);
    tick();
    push(8'hB6);
    tick();
    gpio_en = 1'b0;
    check("rmf_count", 32'(fifo_count), 32'd1);
    repeat (10) tick();
    check("rmf_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rmf_tx", 32'(tx), 32'd1);
    check("rmf_busy", 32'(busy), 32'd0);
    check("rmf_count0", 32'(fifo_count), 32'd0);
    check("rmf_ovf", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2*FB*CPB; i++) begin
      expect_idle("rmf_quiet");
    end
    check("rmf_count_end", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
